sram_bank_ctrl: RTL and testbench

- Sequencing controller and two-requester arbiter for the 2-port SRAM bank, driven by the Bennett phase clock.
- Each Bennett cycle it accepts up to two requests, arbitrates them, and drives the bank with correct phase timing:
  - one-hot word lines on ph3;
  - write data on ph5;
  - ReadEn on ph7;
  - WriteEn on ph9.
- It returns read data and acknowledges to each requester.

---
 rtl/sram_bank_ctrl_if.sv | 33 +++
 rtl/sram_bank_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_ctrl_if.sv
// Requester-side bus of sram_bank_ctrl: two independent request/ack channels, A and B.
interface sram_bank_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = 5
);
    logic                  req_a;
    logic                  we_a;
    logic [AW-1:0]         addr_a;
    logic [DATA_WIDTH-1:0] wdata_a;
    logic                  ack_a;
    logic [DATA_WIDTH-1:0] rdata_a;

    logic                  req_b;
    logic                  we_b;
    logic [AW-1:0]         addr_b;
    logic [DATA_WIDTH-1:0] wdata_b;
    logic                  ack_b;
    logic [DATA_WIDTH-1:0] rdata_b;

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  ack_a, rdata_a,
        input  ack_b, rdata_b
    );

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output ack_a, rdata_a,
        output ack_b, rdata_b
    );
endinterface

// File: rtl/sram_bank_ctrl.sv
// Bennett-phase sequencer and two-requester arbiter for a 2-port SRAM bank.
// Optional conflict counter: define SRAM_BANK_CTRL_STATS_EN.
module sram_bank_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int WORDS      = 32,
    parameter int PHASES     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PHASES-1:0]     clkp,
    sram_bank_ctrl_if.slave       req_bus,
    output logic [WORDS-1:0]      wordA,
    output logic [WORDS-1:0]      wordB,
    output logic                  ReadEn,
    output logic                  WriteEn,
    output logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] outA,
    input  logic [DATA_WIDTH-1:0] outB,
    output logic [15:0]           conflict_cnt
);
    localparam int AW = $clog2(WORDS);
    localparam int PW = $clog2(PHASES);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        ADDR,
        DATA,
        ACCESS,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PHASES-1:0]     clkp_q;
    logic [PHASES-1:0]     rise;
    logic [PW-1:0]         phase_sel;
    logic                  step;

    logic                  both;
    logic                  conflict;
    logic                  take_a;
    logic                  take_b;

    logic                  rr;
    logic                  gnt_a;
    logic                  gnt_b;
    logic                  gnt_we;
    logic [AW-1:0]         addr_a_q;
    logic [AW-1:0]         addr_b_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    function automatic logic [WORDS-1:0] onehot(input logic [AW-1:0] a);
        onehot = WORDS'(1) << a;
    endfunction

    // Each state waits for exactly one phase edge; all other edges are ignored.
    always_comb begin
        rise = clkp & ~clkp_q;
        phase_sel = '0;
        unique case (state)
            IDLE:    phase_sel = PW'(0);
            GRANT:   phase_sel = PW'(2);
            ADDR:    phase_sel = PW'(4);
            DATA:    phase_sel = PW'(6);
            ACCESS:  phase_sel = PW'(8);
            DONE:    phase_sel = PW'(9);
            default: phase_sel = '0;
        endcase
        step = rise[phase_sel];
    end

    always_comb begin
        both     = req_bus.req_a & req_bus.req_b;
        conflict = both & (req_bus.we_a | req_bus.we_b);
        take_a   = req_bus.req_a & ~(conflict & rr);
        take_b   = req_bus.req_b & ~(conflict & ~rr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (step) begin
            unique case (state)
                IDLE:    if (req_bus.req_a || req_bus.req_b) state_nxt = GRANT;
                GRANT:   state_nxt = ADDR;
                ADDR:    state_nxt = DATA;
                DATA:    state_nxt = ACCESS;
                ACCESS:  state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clkp_q          <= '0;
            rr              <= 1'b0;
            gnt_a           <= 1'b0;
            gnt_b           <= 1'b0;
            gnt_we          <= 1'b0;
            addr_a_q        <= '0;
            addr_b_q        <= '0;
            wdata_q         <= '0;
            wordA           <= '0;
            wordB           <= '0;
            ReadEn          <= 1'b0;
            WriteEn         <= 1'b0;
            din             <= '0;
            req_bus.ack_a   <= 1'b0;
            req_bus.ack_b   <= 1'b0;
            req_bus.rdata_a <= '0;
            req_bus.rdata_b <= '0;
        end else begin
            clkp_q        <= clkp;
            req_bus.ack_a <= 1'b0;
            req_bus.ack_b <= 1'b0;
            if (step) begin
                unique case (state)
                    IDLE: begin
                        if (req_bus.req_a || req_bus.req_b) begin
                            gnt_a    <= take_a;
                            gnt_b    <= take_b;
                            gnt_we   <= take_a ? req_bus.we_a : req_bus.we_b;
                            addr_a_q <= req_bus.addr_a;
                            addr_b_q <= req_bus.addr_b;
                            wdata_q  <= take_a ? req_bus.wdata_a : req_bus.wdata_b;
                            // A sole winner hands priority to the other side, so a
                            // deferred loser is first in line even after it runs alone.
                            if (take_a ^ take_b) begin
                                rr <= take_a;
                            end
                        end
                    end
                    GRANT: begin
                        if (gnt_we) begin
                            wordA <= onehot(gnt_a ? addr_a_q : addr_b_q);
                            wordB <= onehot(gnt_a ? addr_a_q : addr_b_q);
                        end else begin
                            wordA <= gnt_a ? onehot(addr_a_q) : '0;
                            wordB <= gnt_b ? onehot(addr_b_q) : '0;
                        end
                    end
                    ADDR: begin
                        if (gnt_we) begin
                            din <= wdata_q;
                        end
                    end
                    DATA: begin
                        if (!gnt_we) begin
                            ReadEn <= 1'b1;
                        end
                    end
                    ACCESS: begin
                        if (gnt_we) begin
                            WriteEn <= 1'b1;
                        end else begin
                            ReadEn <= 1'b0;
                            if (gnt_a) begin
                                req_bus.rdata_a <= outA;
                                req_bus.ack_a   <= 1'b1;
                            end
                            if (gnt_b) begin
                                req_bus.rdata_b <= outB;
                                req_bus.ack_b   <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        WriteEn <= 1'b0;
                        wordA   <= '0;
                        wordB   <= '0;
                        if (gnt_we) begin
                            req_bus.ack_a <= gnt_a;
                            req_bus.ack_b <= gnt_b;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SRAM_BANK_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
        end else if (state == IDLE && step && conflict && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(ReadEn && WriteEn));
    a_ack_a_pulse: assert property (@(posedge clk) disable iff (!reset)
        req_bus.ack_a |=> !req_bus.ack_a);
    a_ack_b_pulse: assert property (@(posedge clk) disable iff (!reset)
        req_bus.ack_b |=> !req_bus.ack_b);
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Scoreboard bench for sram_bank_ctrl: Bennett phases of two clks each, behavioural bank model.
`timescale 1ns/1ps
module tb_sram_bank_ctrl;
    localparam int DW     = 16;
    localparam int WORDS  = 32;
    localparam int AW     = 5;
    localparam int PHASES = 10;
`ifdef SRAM_BANK_CTRL_STATS_EN
    localparam logic STATS = 1'b1;
`else
    localparam logic STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [PHASES-1:0] clkp;
    logic [WORDS-1:0]  wordA, wordB;
    logic              ReadEn, WriteEn;
    logic [DW-1:0]     din, outA, outB;
    logic [15:0]       conflict_cnt;

    sram_bank_ctrl_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

    sram_bank_ctrl #(.DATA_WIDTH(DW), .WORDS(WORDS), .PHASES(PHASES)) dut (
        .clk(clk), .reset(reset), .clkp(clkp), .req_bus(bus),
        .wordA(wordA), .wordB(wordB), .ReadEn(ReadEn), .WriteEn(WriteEn),
        .din(din), .outA(outA), .outB(outB), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Phase generator: phase ph is active for two clks; sub = clk index within the phase.
    int unsigned ph  = 0;
    int unsigned sub = 0;
    initial clkp = 10'b1;
    always @(negedge clk) begin
        if (sub == 1) begin
            sub = 0;
            ph  = (ph == PHASES - 1) ? 0 : ph + 1;
        end else begin
            sub = 1;
        end
        clkp = '0;
        clkp[ph] = 1'b1;
    end

    // Behavioural bank: combinational read ports, write while WriteEn is high.
    logic [DW-1:0] mem    [WORDS];
    logic [DW-1:0] shadow [WORDS];
    function automatic int oh_idx(input logic [WORDS-1:0] w);
        for (int i = 0; i < WORDS; i++) if (w[i]) return i;
        return 0;
    endfunction
    initial for (int i = 0; i < WORDS; i++) begin mem[i] = '0; shadow[i] = '0; end
    assign outA = mem[oh_idx(wordA)];
    assign outB = mem[oh_idx(wordB)];
    always @(posedge clk) if (WriteEn) mem[oh_idx(wordA)] = din;

    typedef struct {
        logic          we;
        logic [DW-1:0] data;
        int unsigned   phase;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];
    int   ack_order[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic issue_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        bus.we_a = we; bus.addr_a = addr; bus.wdata_a = data; bus.req_a = 1'b1;
        e.we = we; e.phase = we ? 9 : 8; e.data = we ? data : shadow[addr];
        if (we) shadow[addr] = data;
        q_a.push_back(e);
    endtask

    task automatic issue_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        bus.we_b = we; bus.addr_b = addr; bus.wdata_b = data; bus.req_b = 1'b1;
        e.we = we; e.phase = we ? 9 : 8; e.data = we ? data : shadow[addr];
        if (we) shadow[addr] = data;
        q_b.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int unsigned p);
        do tick(); while (!(ph == p && sub == 0));
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        int unsigned n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (q_a.size() + q_b.size() !== 0) begin
            errors++;
            $display("FAIL %s_timeout: pending=%0d after %0d clks, required 0", name,
                     q_a.size() + q_b.size(), budget);
            q_a.delete(); q_b.delete();
            bus.req_a = 1'b0; bus.req_b = 1'b0;
        end
    endtask

    // Scoreboard: every ack pops the side's expectation and checks phase and read data.
    always begin : monitor
        exp_t e;
        tick();
        checks++;
        if ((ReadEn & WriteEn) !== 1'b0) begin
            errors++;
            $display("FAIL rw_exclusive: ReadEn=%b WriteEn=%b, required not both", ReadEn, WriteEn);
        end
        if (ph < 2 || ph == 9) begin
            checks++;
            if ((wordA | wordB) !== '0) begin
                errors++;
                $display("FAIL word_idle ph%0d: wordA=%h wordB=%h, required 0", ph + 1, wordA, wordB);
            end
        end
        if (bus.ack_a === 1'b1) begin
            ack_order.push_back(0);
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL ack_a_unexpected: ack_a=1, required 0");
            end else begin
                e = q_a.pop_front();
                checks++;
                if (ph !== e.phase || sub !== 0) begin
                    errors++;
                    $display("FAIL ack_a_phase: at rise[%0d]+%0d, required rise[%0d]", ph, sub, e.phase);
                end
                if (!e.we) begin
                    checks++;
                    if (bus.rdata_a !== e.data) begin
                        errors++;
                        $display("FAIL rdata_a: got %h, required %h", bus.rdata_a, e.data);
                    end
                end
            end
            bus.req_a = 1'b0;
        end
        if (bus.ack_b === 1'b1) begin
            ack_order.push_back(1);
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL ack_b_unexpected: ack_b=1, required 0");
            end else begin
                e = q_b.pop_front();
                checks++;
                if (ph !== e.phase || sub !== 0) begin
                    errors++;
                    $display("FAIL ack_b_phase: at rise[%0d]+%0d, required rise[%0d]", ph, sub, e.phase);
                end
                if (!e.we) begin
                    checks++;
                    if (bus.rdata_b !== e.data) begin
                        errors++;
                        $display("FAIL rdata_b: got %h, required %h", bus.rdata_b, e.data);
                    end
                end
            end
            bus.req_b = 1'b0;
        end
    end

    task automatic test_reset();
        logic [4*WORDS+8*DW+2+16+2-1:0] all_out;
        all_out = {wordA, wordB, ReadEn, WriteEn, din, bus.ack_a, bus.ack_b,
                   bus.rdata_a, bus.rdata_b, conflict_cnt, 2'b00, {(2*WORDS+4*DW){1'b0}}};
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        checks++;
        if (wordA !== '0 || wordB !== '0) begin
            errors++;
            $display("FAIL reset_words: wordA=%h wordB=%h, required 0", wordA, wordB);
        end
        checks++;
        if ({ReadEn, WriteEn, bus.ack_a, bus.ack_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 0000", {ReadEn, WriteEn, bus.ack_a, bus.ack_b});
        end
    endtask

    task automatic test_write_a();
        logic [WORDS-1:0] ew;
        wait_phase(9);
        issue_a(1'b1, 5'd1, 16'hAAAA);
        wait_phase(0);
        for (int unsigned i = 0; i < 20; i++) begin
            ew = (ph >= 2 && ph <= 8) ? 32'h0000_0002 : 32'h0;
            checks++;
            if (wordA !== ew || wordB !== ew) begin
                errors++;
                $display("FAIL wr_a_word ph%0d: wordA=%h wordB=%h, required %h", ph + 1, wordA, wordB, ew);
            end
            checks++;
            if ({ReadEn, WriteEn} !== {1'b0, ph == 8}) begin
                errors++;
                $display("FAIL wr_a_strobe ph%0d: ReadEn/WriteEn=%b%b, required 0%b", ph + 1, ReadEn, WriteEn, ph == 8);
            end
            if (ph >= 4) begin
                checks++;
                if (din !== 16'hAAAA) begin
                    errors++;
                    $display("FAIL wr_a_din ph%0d: got %h, required aaaa", ph + 1, din);
                end
            end
            tick();
        end
        wait_done("write_a", 20);
    endtask

    task automatic test_write_b();
        logic [WORDS-1:0] ew;
        wait_phase(9);
        issue_b(1'b1, 5'd0, 16'hABCD);
        wait_phase(0);
        for (int unsigned i = 0; i < 20; i++) begin
            ew = (ph >= 2 && ph <= 8) ? 32'h0000_0001 : 32'h0;
            checks++;
            if (wordA !== ew || wordB !== ew) begin
                errors++;
                $display("FAIL wr_b_word ph%0d: wordA=%h wordB=%h, required %h", ph + 1, wordA, wordB, ew);
            end
            checks++;
            if ({ReadEn, WriteEn} !== {1'b0, ph == 8}) begin
                errors++;
                $display("FAIL wr_b_strobe ph%0d: ReadEn/WriteEn=%b%b, required 0%b", ph + 1, ReadEn, WriteEn, ph == 8);
            end
            if (ph >= 4) begin
                checks++;
                if (din !== 16'hABCD) begin
                    errors++;
                    $display("FAIL wr_b_din ph%0d: got %h, required abcd", ph + 1, din);
                end
            end
            tick();
        end
        wait_done("write_b", 20);
    endtask

    task automatic test_dual_read();
        logic [WORDS-1:0] ea, eb;
        wait_phase(9);
        issue_a(1'b0, 5'd1, '0);
        issue_b(1'b0, 5'd0, '0);
        wait_phase(0);
        for (int unsigned i = 0; i < 20; i++) begin
            ea = (ph >= 2 && ph <= 8) ? 32'h0000_0002 : 32'h0;
            eb = (ph >= 2 && ph <= 8) ? 32'h0000_0001 : 32'h0;
            checks++;
            if (wordA !== ea || wordB !== eb) begin
                errors++;
                $display("FAIL rd_word ph%0d: wordA=%h wordB=%h, required %h %h", ph + 1, wordA, wordB, ea, eb);
            end
            checks++;
            if ({ReadEn, WriteEn} !== {(ph == 6 || ph == 7), 1'b0}) begin
                errors++;
                $display("FAIL rd_strobe ph%0d: ReadEn/WriteEn=%b%b, required %b0", ph + 1, ReadEn, WriteEn, (ph == 6 || ph == 7));
            end
            if (ph == 8 && sub == 0) begin
                checks++;
                if ({bus.ack_a, bus.ack_b} !== 2'b11) begin
                    errors++;
                    $display("FAIL rd_ack_same_clk: ack_a/ack_b=%b%b, required 11", bus.ack_a, bus.ack_b);
                end
            end
            tick();
        end
        wait_done("dual_read", 20);
    endtask

    task automatic test_conflict();
        logic [AW-1:0] aa [3] = '{5'd2, 5'd4, 5'd2};
        logic [AW-1:0] ab [3] = '{5'd3, 5'd5, 5'd2};
        logic [DW-1:0] da [3] = '{16'h1111, 16'h3333, 16'h0000};
        logic [DW-1:0] db [3] = '{16'h2222, 16'h4444, 16'h5555};
        logic          wa [3] = '{1'b1, 1'b1, 1'b0};
        for (int unsigned r = 0; r < 3; r++) begin
            ack_order.delete();
            wait_phase(9);
            issue_a(wa[r], aa[r], da[r]);
            issue_b(1'b1, ab[r], db[r]);
            wait_done("conflict", 60);
            checks++;
            if (ack_order.size() !== 2 || ack_order[0] !== 0 || ack_order[1] !== 1) begin
                errors++;
                $display("FAIL conflict_order round %0d: %0d acks, first side %0d, required 2 acks A then B",
                         r, ack_order.size(), ack_order.size() > 0 ? ack_order[0] : -1);
            end
            checks++;
            if (conflict_cnt !== (STATS ? 16'(r + 1) : 16'd0)) begin
                errors++;
                $display("FAIL conflict_cnt round %0d: got %0d, required %0d", r, conflict_cnt,
                         STATS ? r + 1 : 0);
            end
        end
        ack_order.delete();
        wait_phase(9);
        issue_a(1'b0, 5'd2, '0);
        issue_b(1'b0, 5'd5, '0);
        wait_done("readback", 30);
        checks++;
        if (conflict_cnt !== (STATS ? 16'd3 : 16'd0)) begin
            errors++;
            $display("FAIL conflict_cnt_dual_read: got %0d, required %0d", conflict_cnt, STATS ? 3 : 0);
        end
    endtask

    task automatic test_reset_mid();
        wait_phase(9);
        issue_a(1'b0, 5'd1, '0);
        wait_phase(6);
        checks++;
        if (ReadEn !== 1'b1) begin
            errors++;
            $display("FAIL mid_readen: got %b, required 1", ReadEn);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({wordA, wordB, din, bus.rdata_a, bus.rdata_b} !== '0) begin
            errors++;
            $display("FAIL mid_reset_data: wordA=%h wordB=%h din=%h rdata_a=%h, required 0",
                     wordA, wordB, din, bus.rdata_a);
        end
        checks++;
        if ({ReadEn, WriteEn, bus.ack_a, bus.ack_b, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: ReadEn=%b WriteEn=%b ack=%b%b cnt=%0d, required 0",
                     ReadEn, WriteEn, bus.ack_a, bus.ack_b, conflict_cnt);
        end
        wait_phase(7);
        reset = 1'b1;
        wait_done("reset_mid", 30);
    endtask

    task automatic test_late_req();
        logic [WORDS-1:0] eb;
        wait_phase(1);
        issue_b(1'b0, 5'd3, '0);
        for (int unsigned i = 0; i < 18; i++) begin
            checks++;
            if (wordB !== '0 || ReadEn !== 1'b0) begin
                errors++;
                $display("FAIL late_no_grant ph%0d: wordB=%h ReadEn=%b, required 0 0", ph + 1, wordB, ReadEn);
            end
            tick();
        end
        for (int unsigned i = 0; i < 20; i++) begin
            eb = (ph >= 2 && ph <= 8) ? 32'h0000_0008 : 32'h0;
            checks++;
            if (wordB !== eb || wordA !== '0) begin
                errors++;
                $display("FAIL late_word ph%0d: wordA=%h wordB=%h, required 0 %h", ph + 1, wordA, wordB, eb);
            end
            checks++;
            if (ReadEn !== (ph == 6 || ph == 7)) begin
                errors++;
                $display("FAIL late_readen ph%0d: got %b, required %b", ph + 1, ReadEn, (ph == 6 || ph == 7));
            end
            tick();
        end
        wait_done("late_req", 10);
    endtask

    initial begin
        reset = 1'b0;
        bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
        bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
        repeat (3) tick();
        test_reset();
        reset = 1'b1;
        test_write_a();
        test_write_b();
        test_dual_read();
        test_conflict();
        test_reset_mid();
        test_late_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
